// File: rtl/red_pitaya_sys_master.sv
// Single-outstanding system-bus initiator: valid/ready request in, one strobe on sys_*,
// one response out, with a saturating WAIT-cycle timeout so a silent bus cannot hang it.
module red_pitaya_sys_master #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_sel_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        rsp_timeout_o,
   output logic        busy_o,
   output logic [31:0] sys_addr,
   output logic [31:0] sys_wdata,
   output logic [3:0]  sys_sel,
   output logic        sys_wen,
   output logic        sys_ren,
   input  logic [31:0] sys_rdata,
   input  logic        sys_err,
   input  logic        sys_ack
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] STRB = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [16:0] TimeoutLim = 17'(TIMEOUT);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q;
   logic        wr_q;
   logic        done, tmo;

   // Counter value for this WAIT cycle is cnt_q+1; an ack on that same cycle wins.
   always_comb begin
      done = (state_q == WAIT) && (sys_ack || sys_err);
      tmo  = (state_q == WAIT) && !done && (({1'b0, cnt_q} + 17'd1) >= TimeoutLim);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = STRB;
         STRB:    state_d = WAIT;
         WAIT:    if (done || tmo) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Held low while reset is asserted so every output reads 0 during reset.
   assign req_ready_o = rstn_i && (state_q == IDLE);

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         wr_q          <= 1'b0;
         busy_o        <= 1'b0;
         sys_addr      <= '0;
         sys_wdata     <= '0;
         sys_sel       <= '0;
         sys_wen       <= 1'b0;
         sys_ren       <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_o  <= (state_d != IDLE);
         sys_wen <= 1'b0;
         sys_ren <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  wr_q      <= req_write_i;
                  sys_addr  <= req_addr_i;
                  sys_wdata <= req_wdata_i;
                  sys_sel   <= req_sel_i;
                  sys_wen   <= req_write_i;
                  sys_ren   <= !req_write_i;
               end
            end
            STRB: cnt_q <= '0;
            WAIT: begin
               if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
               if (done) begin
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= sys_err;
                  rsp_timeout_o <= 1'b0;
                  rsp_rdata_o   <= wr_q ? 32'd0 : sys_rdata;
               end else if (tmo) begin
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b1;
                  rsp_timeout_o <= 1'b1;
                  rsp_rdata_o   <= 32'd0;
               end
            end
            RESP: if (rsp_ready_i) rsp_valid_o <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_red_pitaya_sys_master.sv
// Table-driven bench for red_pitaya_sys_master with a small registered responder model.
module tb_red_pitaya_sys_master;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_write_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic [3:0]  req_sel_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic        busy_o;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic [3:0]  sys_sel;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   always #5 clk_i = ~clk_i;

   red_pitaya_sys_master #(.TIMEOUT(255)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_sel_i(req_sel_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
      .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
      .sys_err(sys_err), .sys_ack(sys_ack)
   );

   // Responder: mode 0 silent, 1 normal (addr 0 reads 1), 2 ack+err with 0xDEADBEEF.
   logic [1:0]  mode = 2'd0;
   logic        force_ack = 1'b0;
   logic        r_ack = 1'b0, r_err = 1'b0;
   logic [31:0] r_rdata = '0;
   logic [31:0] mem [16];

   always @(posedge clk_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (mode != 2'd0 && (sys_wen || sys_ren)) begin
         r_ack <= 1'b1;
         r_err <= (mode == 2'd2);
         if (sys_wen && mode == 2'd1) mem[sys_addr[5:2]] <= sys_wdata;
         if (mode == 2'd2)               r_rdata <= 32'hDEADBEEF;
         else if (sys_addr[5:2] == 4'd0) r_rdata <= 32'd1;
         else                            r_rdata <= mem[sys_addr[5:2]];
      end
   end

   assign sys_ack   = r_ack | force_ack;
   assign sys_err   = r_err;
   assign sys_rdata = r_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] all_outs_or();
      return {31'd0, |{sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren, rsp_valid_o,
                       rsp_rdata_o, rsp_err_o, rsp_timeout_o, busy_o, req_ready_o}};
   endfunction

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [1:0]  mode;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_tmo;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input int idx, input vec_t v);
      int n = 0;
      int wen_cnt = 0;
      int ren_cnt = 0;
      int first_strb = 0;
      bit addr_ok = 1'b1;
      bit seen = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_req_ready", idx), {31'd0, req_ready_o}, 32'd1);
      mode        = v.mode;
      req_valid_i = 1'b1;
      req_write_i = v.write;
      req_addr_i  = v.addr;
      req_wdata_i = v.wdata;
      req_sel_i   = v.sel;
      while (!seen && n < 400) begin
         @(negedge clk_i);
         n++;
         req_valid_i = 1'b0;
         if (sys_wen) wen_cnt++;
         if (sys_ren) ren_cnt++;
         if ((sys_wen || sys_ren) && first_strb == 0) first_strb = n;
         if (busy_o && sys_addr !== v.addr) addr_ok = 1'b0;
         if (rsp_valid_o) seen = 1'b1;
      end
      chk($sformatf("v%0d_latency", idx), seen ? n : -1, v.lat);
      chk($sformatf("v%0d_strobe_cycle", idx), first_strb, 1);
      chk($sformatf("v%0d_wen_count", idx), wen_cnt, {31'd0, v.write});
      chk($sformatf("v%0d_ren_count", idx), ren_cnt, {31'd0, !v.write});
      chk($sformatf("v%0d_addr_stable", idx), {31'd0, addr_ok}, 32'd1);
      chk($sformatf("v%0d_rdata", idx), rsp_rdata_o, v.exp_rdata);
      chk($sformatf("v%0d_err", idx), {31'd0, rsp_err_o}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_timeout", idx), {31'd0, rsp_timeout_o}, {31'd0, v.exp_tmo});
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk($sformatf("v%0d_rsp_drop", idx), {30'd0, rsp_valid_o, req_ready_o}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bit ok;
      vecs[0] = '{1'b0, 32'h0,  32'h0,        4'hF, 2'd1, 32'h00000001, 1'b0, 1'b0, 3};
      vecs[1] = '{1'b1, 32'h30, 32'h000000FE, 4'hF, 2'd1, 32'h0,        1'b0, 1'b0, 3};
      vecs[2] = '{1'b0, 32'h30, 32'h0,        4'hF, 2'd1, 32'h000000FE, 1'b0, 1'b0, 3};
      vecs[3] = '{1'b0, 32'h10, 32'h0,        4'hF, 2'd0, 32'h0,        1'b1, 1'b1, 257};
      vecs[4] = '{1'b0, 32'h10, 32'h0,        4'hF, 2'd2, 32'hDEADBEEF, 1'b1, 1'b0, 3};
      vecs[5] = '{1'b1, 32'h34, 32'h12345678, 4'h3, 2'd1, 32'h0,        1'b0, 1'b0, 3};
      vecs[6] = '{1'b0, 32'h34, 32'h0,        4'hF, 2'd1, 32'h12345678, 1'b0, 1'b0, 3};
      vecs[7] = '{1'b1, 32'h38, 32'hCAFEF00D, 4'hF, 2'd2, 32'h0,        1'b1, 1'b0, 3};

      repeat (2) @(negedge clk_i);
      chk("reset_outputs_zero", all_outs_or(), 32'd0);
      rstn_i = 1'b1;
      @(negedge clk_i);
      chk("post_reset_idle", {29'd0, req_ready_o, busy_o, sys_ren}, 32'd4);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Response backpressure with a request waiting the whole time.
      mode = 2'd1;
      @(negedge clk_i);
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0;
      n = 0;
      while (!rsp_valid_o && n < 20) begin @(negedge clk_i); n++; end
      chk("bp_rsp_seen", {31'd0, rsp_valid_o}, 32'd1);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (!rsp_valid_o || rsp_rdata_o !== 32'd1 || rsp_err_o || req_ready_o || sys_ren)
            ok = 1'b0;
      end
      chk("bp_held_stable", {31'd0, ok}, 32'd1);
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk("bp_after_hs_c1", {29'd0, rsp_valid_o, req_ready_o, sys_ren}, 32'd2);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      chk("bp_after_hs_c2_ren", {31'd0, sys_ren}, 32'd1);
      n = 0;
      while (!rsp_valid_o && n < 20) begin @(negedge clk_i); n++; end
      chk("bp_second_rdata", rsp_rdata_o, 32'd1);
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;

      // Reset during WAIT, then a late ack.
      mode = 2'd0;
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h20;
      @(negedge clk_i);
      req_valid_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("mid_busy_before_reset", {31'd0, busy_o}, 32'd1);
      rstn_i = 1'b0;
      @(negedge clk_i);
      chk("mid_reset_outputs_zero", all_outs_or(), 32'd0);
      rstn_i = 1'b1;
      force_ack = 1'b1;
      @(negedge clk_i);
      chk("mid_release_idle", {28'd0, sys_ren, rsp_valid_o, busy_o, req_ready_o}, 32'd1);
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk_i);
         if (rsp_valid_o || busy_o || sys_ren || sys_wen) ok = 1'b0;
      end
      force_ack = 1'b0;
      chk("mid_late_ack_ignored", {31'd0, ok}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
